// File: rtl/divisor_pkg.sv
// rtl/divisor_pkg.sv - shared state encoding and default width for the sequential divider
package divisor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } divState_t;

endpackage

// File: rtl/restador_paso.sv
// rtl/restador_paso.sv - WIDTH+1-bit subtract with borrow out for one restoring division step
module restador_paso #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] difference,
  output logic           borrowOut
);

  assign {borrowOut, difference} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule

// File: rtl/divisor_secuencial.sv
// rtl/divisor_secuencial.sv - restoring sequential divider, one quotient bit per cycle
// Optional DIVISOR_SIGNED_EN: two's complement operands with sign fix-up on the DONE transition.
module divisor_secuencial
  import divisor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  divState_t        state, stateNext;
  logic [WIDTH-1:0] remReg, quoReg, divReg;
  logic [CW-1:0]    stepCnt;
  logic [WIDTH:0]   shifted, diff;
  logic             borrow, keepDiff;
  logic [WIDTH-1:0] remStep, quoStep, remFinal, quoFinal;
  logic [WIDTH-1:0] magDividend, magDivisor;
  logic             accept, zeroDiv, lastStep;

  assign accept   = start && (state != CALC);
  assign zeroDiv  = (divisor == '0);
  assign lastStep = (state == CALC) && (stepCnt == CW'(1));
  assign busy     = (state == CALC);
  assign done     = (state == DONE);

  assign shifted = {remReg, quoReg[WIDTH-1]};

  restador_paso #(.WIDTH(WIDTH)) uRestador (
    .minuend    (shifted),
    .subtrahend ({1'b0, divReg}),
    .difference (diff),
    .borrowOut  (borrow)
  );

  // Partial remainder stays below the divisor, so a kept difference never sets its top bit.
  assign keepDiff = ~borrow & ~diff[WIDTH];
  assign remStep  = keepDiff ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quoStep  = {quoReg[WIDTH-2:0], keepDiff};

`ifdef DIVISOR_SIGNED_EN
  logic negQuo, negRem;
  assign magDividend = dividend[WIDTH-1] ? -dividend : dividend;
  assign magDivisor  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign quoFinal    = negQuo ? -quoStep : quoStep;
  assign remFinal    = negRem ? -remStep : remStep;

  always_ff @(posedge clk) begin
    if (reset) begin
      negQuo <= 1'b0;
      negRem <= 1'b0;
    end else if (accept) begin
      negQuo <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      negRem <= dividend[WIDTH-1];
    end
  end
`else
  assign magDividend = dividend;
  assign magDivisor  = divisor;
  assign quoFinal    = quoStep;
  assign remFinal    = remStep;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: begin
        if (start)             stateNext = zeroDiv ? DONE : CALC;
        else if (state == DONE) stateNext = IDLE;
      end
      CALC:    if (stepCnt == CW'(1)) stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remReg    <= '0;
      quoReg    <= '0;
      divReg    <= '0;
      stepCnt   <= '0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
    end else if (accept && zeroDiv) begin
      quotient  <= '1;
      remainder <= dividend;
      divByZero <= 1'b1;
    end else if (accept) begin
      remReg  <= '0;
      quoReg  <= magDividend;
      divReg  <= magDivisor;
      stepCnt <= CW'(WIDTH);
    end else if (state == CALC) begin
      remReg  <= remStep;
      quoReg  <= quoStep;
      stepCnt <= stepCnt - CW'(1);
      if (lastStep) begin
        quotient  <= quoFinal;
        remainder <= remFinal;
        divByZero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb/tb_divisor_secuencial.sv - directed self-checking bench for divisor_secuencial (WIDTH=8)
module tb_divisor_secuencial;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] dividend, divisor;
  logic       busy, done, divByZero;
  logic [7:0] quotient, remainder;

  int tests = 0;
  int fails = 0;
  int cyc, busyCnt, qChanged, doneSeen;

  divisor_secuencial #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .divByZero (divByZero)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents start for one edge; returns in cycle 1 of the new operation.
  task automatic startOp(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick;
    start    = 1'b0;
  endtask

  task automatic waitDone(input int startCyc, input logic [7:0] qBefore,
                          output int c, output int nBusy, output int qChg);
    c = startCyc;
    nBusy = 0;
    qChg = 0;
    while (done !== 1'b1 && c < 40) begin
      if (busy === 1'b1) nBusy++;
      if (quotient !== qBefore) qChg = 1;
      tick;
      c++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick; tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quo", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", divByZero, 0);
    reset = 1'b0;
    tick;

    startOp(8'd100, 8'd7);
    waitDone(1, 8'd0, cyc, busyCnt, qChanged);
    chk("d100_7_cycle", cyc, 9);
    chk("d100_7_busycnt", busyCnt, 8);
    chk("d100_7_hold_in_calc", qChanged, 0);
    chk("d100_7_busy_at_done", busy, 0);
    chk("d100_7_quo", quotient, 14);
    chk("d100_7_rem", remainder, 2);
    chk("d100_7_dbz", divByZero, 0);
    tick;
    chk("d100_7_done_pulse", done, 0);
    chk("d100_7_quo_hold", quotient, 14);

    startOp(8'd5, 8'd0);
    chk("d5_0_done", done, 1);
    chk("d5_0_busy", busy, 0);
    chk("d5_0_quo", quotient, 8'hFF);
    chk("d5_0_rem", remainder, 5);
    chk("d5_0_dbz", divByZero, 1);
    tick;
    chk("d5_0_done_pulse", done, 0);

    startOp(8'd200, 8'd3);
    repeat (3) tick;
    dividend = 8'd9; divisor = 8'd9; start = 1'b1;
    tick;
    start = 1'b0;
    waitDone(5, 8'hFF, cyc, busyCnt, qChanged);
    chk("d200_3_cycle", cyc, 9);
    chk("d200_3_hold_in_calc", qChanged, 0);
    chk("d200_3_quo", quotient, 66);
    chk("d200_3_rem", remainder, 2);
    chk("d200_3_dbz_clear", divByZero, 0);
    tick;

    startOp(8'd255, 8'd1);
    repeat (4) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quo", quotient, 0);
    chk("abort_rem", remainder, 0);
    chk("abort_dbz", divByZero, 0);
    doneSeen = 0;
    repeat (12) begin
      if (done === 1'b1) doneSeen = 1;
      tick;
    end
    chk("abort_no_done", doneSeen, 0);
    startOp(8'd255, 8'd1);
    waitDone(1, 8'd0, cyc, busyCnt, qChanged);
    chk("d255_1_cycle", cyc, 9);
    chk("d255_1_quo", quotient, 255);
    chk("d255_1_rem", remainder, 0);
    tick;

    startOp(8'd100, 8'd7);
    waitDone(1, 8'd255, cyc, busyCnt, qChanged);
    chk("b2b_first_cycle", cyc, 9);
    chk("b2b_first_quo", quotient, 14);
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    tick;
    start = 1'b0;
    chk("b2b_busy_after_done", busy, 1);
    waitDone(1, 8'd14, cyc, busyCnt, qChanged);
    chk("b2b_second_cycle", cyc, 9);
    chk("b2b_second_busycnt", busyCnt, 8);
    chk("b2b_second_quo", quotient, 10);
    chk("b2b_second_rem", remainder, 0);
    tick;

    startOp(8'hF9, 8'd2);
    waitDone(1, 8'd10, cyc, busyCnt, qChanged);
    chk("f9_2_cycle", cyc, 9);
`ifdef DIVISOR_SIGNED_EN
    chk("f9_2_quo", quotient, 8'hFD);
    chk("f9_2_rem", remainder, 8'hFF);
`else
    chk("f9_2_quo", quotient, 124);
    chk("f9_2_rem", remainder, 1);
`endif
    tick;

    startOp(8'h80, 8'hFF);
    waitDone(1, quotient, cyc, busyCnt, qChanged);
    chk("80_ff_cycle", cyc, 9);
`ifdef DIVISOR_SIGNED_EN
    chk("80_ff_quo", quotient, 8'h80);
    chk("80_ff_rem", remainder, 0);
`else
    chk("80_ff_quo", quotient, 0);
    chk("80_ff_rem", remainder, 8'h80);
`endif
    chk("80_ff_dbz", divByZero, 0);
    tick;

    reset = 1'b1; start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick;
    reset = 1'b0; start = 1'b0;
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_quo", quotient, 0);
    tick;
    chk("rst_prio_idle", busy, 0);
    chk("rst_prio_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/divisor_secuencial.md
DIVISOR_SECUENCIAL -- requirements
Module: divisor_secuencial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand, quotient and remainder width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request to begin a division; sampled only in IDLE or DONE.
REQ-005 SHALL have port dividend, input, WIDTH: numerator, captured on the accepted start.
REQ-006 SHALL have port divisor, input, WIDTH: denominator, captured on the accepted start.
REQ-007 SHALL have port busy, output, 1: high while in CALC.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when the result becomes valid.
REQ-009 SHALL have port quotient, output, WIDTH: result, held stable from done until the next accepted start.
REQ-010 SHALL have port remainder, output, WIDTH: remainder, with the same hold rule as quotient.
REQ-011 SHALL have port divByZero, output, 1: flag for the last result, with the same hold rule as quotient.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-013 SHALL transition from IDLE or DONE to CALC when start=1 and divisor!=0, capturing both operands and loading step count WIDTH.
REQ-014 SHALL perform one restoring step per CALC cycle:
- shift {partial remainder, dividend} left by 1;
- subtract divisor using a WIDTH+1-bit subtract;
- if no borrow, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
REQ-015 SHALL transition CALC to DONE after exactly WIDTH steps, so that a start accepted in cycle 0 produces done in cycle WIDTH+1.
REQ-016 SHALL treat start=1 with divisor=0 as a divide-by-zero: go directly to DONE with done in cycle 1, quotient all ones, remainder=dividend and divByZero=1.
REQ-017 SHALL ignore start while in CALC, with no effect on the operation in progress or its result.
REQ-018 SHALL accept start=1 during the DONE cycle as a new operation (back-to-back); done still pulses for that cycle.
REQ-019 SHALL keep divByZero cleared for every non-zero-divisor result.
REQ-020 SHALL not change quotient, remainder or divByZero during CALC; they change only on the cycle done rises.

Reset
REQ-021 SHALL, on reset=1 at a clock edge, go to IDLE and set busy=0, done=0, quotient=0, remainder=0 and divByZero=0, from any state.
REQ-022 SHALL, if reset is asserted mid-CALC, abandon the operation with no done pulse; reset has priority over a simultaneous start.

Configuration
REQ-023 SHALL support macro DIVISOR_SIGNED_EN; when it is undefined, all operands and results are unsigned.
REQ-024 SHALL, with DIVISOR_SIGNED_EN defined, treat operands as two's complement:
- divide the magnitudes through the same unsigned core;
- quotient truncates toward zero; remainder takes the sign of the dividend;
- sign fix-up is applied in the DONE transition without adding latency.
REQ-025 SHALL, with DIVISOR_SIGNED_EN defined, produce quotient=most-negative value and remainder=0 for most-negative / -1 (divByZero=0); divide-by-zero gives quotient all ones and remainder=dividend.

Structure
REQ-026 SHALL define the state encoding (IDLE, CALC, DONE) and the default WIDTH constant in shared package divisor_pkg.
REQ-027 SHALL implement the WIDTH+1-bit subtract-with-borrow in sub-module restador_paso (ports: minuend, subtrahend, difference, borrowOut), instantiated once.

Verification (WIDTH=8)
REQ-028 SHALL cover: start, 100/7 -> done in cycle 9, quotient=14, remainder=2, divByZero=0, busy high cycles 1-8.
REQ-029 SHALL cover: start, 5/0 -> done in cycle 1, quotient=255, remainder=5, divByZero=1, busy never high.
REQ-030 SHALL cover: start 200/3, then start 9/9 in cycle 4 -> the second start is ignored; result is quotient=66, remainder=2 at cycle 9.
REQ-031 SHALL cover: start 255/1, reset in cycle 5 -> no done, all outputs 0, IDLE in cycle 6; a new start 255/1 then gives quotient=255, remainder=0.
REQ-032 SHALL cover: back-to-back start in the DONE cycle of 100/7, with 50/5 -> second done exactly 9 cycles later, quotient=10, remainder=0.
REQ-033 SHALL cover: dividend 0xF9, divisor 2:
- with DIVISOR_SIGNED_EN: quotient=0xFD (-3), remainder=0xFF (-1);
- without it: quotient=124, remainder=1;
- with DIVISOR_SIGNED_EN, 0x80/0xFF: quotient=0x80, remainder=0.
